mod_m_counter_prog: RTL and testbench
=====================================

Name: mod_m_counter_prog

Overview:
Runtime-programmable mod-M counter, the generalised successor of the fixed mod-M counter. Adds a writable modulus, up/down direction, synchronous load, and a free-run / one-shot mode driven by a small FSM. Used as a timebase, divider and event timer in datapath and control blocks. Cascadable through complete_tick.

Parameters:
N, 8, counter and modulus width in bits
M_DEFAULT, 5, modulus after reset; legal range 1..2^N-1

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
en  input  1  count enable; count advances only when en=1
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of load_val into count
load_val  input  N  load value
mod_wr  input  1  write mod_val into the modulus register
mod_val  input  N  new modulus M
one_shot  input  1  0 = free-run, 1 = one-shot
start  input  1  one-shot trigger
count  output  N  current count (registered)
complete_tick  output  1  terminal-count indication (combinational), one cycle per wrap
done  output  1  one-shot finished (registered)
mod_q  output  N  current modulus (registered)

Behaviour:
- Reset (reset=0, asynchronous): count=0, mod_q=M_DEFAULT, FSM=IDLE, done=0. Outputs hold these values until the first rising edge after reset=1. Reset asserted mid-count aborts the count immediately with no tick.
- Modulus: on mod_wr=1 with mod_val!=0, mod_q<=mod_val next edge. mod_val=0 is ignored and mod_q is unchanged. A new modulus takes effect from the next cycle.
- Terminal value: up: count>=mod_q-1; down: count==0.
- complete_tick = en & (FSM==RUN) & terminal & ~load. Purely combinational, same cycle as the terminal count.
- Count update priority, highest first:
  1. load: count<=min(load_val, mod_q-1). FSM unchanged.
  2. start while FSM is IDLE or DONE and one_shot=1: count<=0 if up_dn=1, else mod_q-1. FSM goes to RUN and done<=0.
  3. en & RUN:
     - up: terminal ? 0 : count+1
     - down: count==0 ? mod_q-1 : (count>mod_q-1 ? mod_q-1 : count-1)
     - In down mode, clamping an out-of-range count does not raise a tick.
  4. Otherwise count holds.
- Out-of-range count after a modulus shrink: in up mode the >= compare forces a wrap to 0 with a tick on the next enabled cycle.
- mod_q=1: count stays 0; complete_tick=1 on every enabled RUN cycle.
- Arithmetic is N-bit unsigned. No counter overflow is possible because count<=mod_q-1<=2^N-2.
- FSM states: IDLE, RUN, DONE.
  - IDLE: goes to RUN when one_shot=0 (next edge, count unchanged) or when start=1.
  - RUN, one_shot=1: on complete_tick the count takes its wrap value, FSM goes to DONE and done<=1.
  - RUN, one_shot=0: stays in RUN; wraps indefinitely.
  - DONE: count holds and en is ignored. start=1 goes to RUN with a reload and done<=0. one_shot=0 goes to RUN with done<=0 and no reload.
  - start in RUN is ignored.
- up_dn may change on any cycle and takes effect on that edge.
- Simultaneous mod_wr and count update: the count step uses the old mod_q.

Decomposition:
- Shared package: FSM state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width/modulus constants.
- One natural sub-module: mod_m_next, a combinational next-count/terminal calculator (inputs count, mod_q, up_dn; outputs next, terminal). It is reusable by later multi-channel variants.
- The FSM and registers stay in the top-level block.

Test Plan:
- Reset value check, free-run up: reset low mid-count -> count=0, mod_q=5, done=0 immediately. Release with en=1, one_shot=0 -> after the IDLE->RUN cycle count runs 0,1,2,3,4,0. complete_tick high only while count=4.
- Free-run down, M=5: count sequence 0,4,3,2,1,0. complete_tick high while count=0.
- Modulus shrink: count=7 with mod_q=10, then mod_wr with mod_val=4, up -> next enabled cycle count=0 with a tick. Then period is 4. mod_val=0 -> mod_q stays 4.
- One-shot up, M=3: start -> count 0,1,2, tick at 2. Then count=0, done=1 and count holds with en=1. start again -> done=0 and the sequence repeats.
- Load priority: load=1, load_val=9, mod_q=5, with en=1 and a terminal count in the same cycle -> count=4, no tick. load with start in the same cycle -> count=load value, FSM unchanged.
- mod_q=1 with en toggling -> count stays 0; complete_tick equals en in RUN.

Source files
------------

// File: rtl/mod_m_counter_prog_pkg.sv
// Shared types and defaults for the programmable mod-M counter family.
// Holds the one-shot FSM encoding and the width and modulus that apply after reset.
package mod_m_counter_prog_pkg;

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_M = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_m_counter_prog_next.sv
// Combinational next-count and terminal-count calculator for one counter channel.
// It has no state, so several channels can share this block.
module mod_m_next #(
  parameter int N = 8
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] mod_q,
  input  logic         up_dn,
  output logic [N-1:0] next,
  output logic         terminal
);

  logic [N-1:0] top_val;

  assign top_val = mod_q - N'(1);

  always_comb begin
    next     = count;
    terminal = 1'b0;
    if (up_dn) begin
      // >= rather than == so that a count above a shrunken modulus wraps to 0.
      terminal = (count >= top_val);
      next     = terminal ? '0 : count + N'(1);
    end else begin
      // An out-of-range count is clamped to top_val. That clamp is not terminal.
      terminal = (count == '0);
      if (terminal)
        next = top_val;
      else if (count > top_val)
        next = top_val;
      else
        next = count - N'(1);
    end
  end

endmodule

// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable mod-M counter: writable modulus, up/down, load, free-run/one-shot.
// The IDLE/RUN/DONE FSM and all registers live here; next-count math is in mod_m_next.
module mod_m_counter_prog
  import mod_m_counter_prog_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int M_DEFAULT = DEFAULT_M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         mod_wr,
  input  logic [N-1:0] mod_val,
  input  logic         one_shot,
  input  logic         start,
  output logic [N-1:0] count,
  output logic         complete_tick,
  output logic         done,
  output logic [N-1:0] mod_q,
  output state_t       fsm_state
);

  state_t       state_r, state_n;
  logic [N-1:0] count_n;
  logic         done_n;
  logic [N-1:0] step_val;
  logic         terminal;
  logic [N-1:0] top_val;
  logic [N-1:0] load_clamped;
  logic         trigger;

  mod_m_next #(.N(N)) u_next (
    .count    (count),
    .mod_q    (mod_q),
    .up_dn    (up_dn),
    .next     (step_val),
    .terminal (terminal)
  );

  assign top_val       = mod_q - N'(1);
  assign load_clamped  = (load_val > top_val) ? top_val : load_val;
  assign trigger       = start & one_shot & (state_r != RUN);
  assign complete_tick = en & (state_r == RUN) & terminal & ~load;
  assign fsm_state     = state_r;

  always_comb begin
    state_n = state_r;
    count_n = count;
    done_n  = done;
    if (load) begin
      count_n = load_clamped;
    end else if (trigger) begin
      count_n = up_dn ? '0 : top_val;
      state_n = RUN;
      done_n  = 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (!one_shot) state_n = RUN;
        end
        RUN: begin
          if (en) begin
            count_n = step_val;
            if (one_shot && terminal) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
        DONE: begin
          // en is ignored here. Leaving one-shot mode resumes from the held count.
          if (!one_shot) begin
            state_n = RUN;
            done_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n;
      count   <= count_n;
      done    <= done_n;
    end
  end

  // The count step above reads the old modulus, because of the register boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mod_q <= N'(M_DEFAULT);
    else if (mod_wr && (mod_val != '0))
      mod_q <= mod_val;
  end

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Randomised and directed bench for mod_m_counter_prog against a behavioural model.
module tb_mod_m_counter_prog;
  import mod_m_counter_prog_pkg::*;

  localparam int N = 8;
  localparam int M_DEF = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0, up_dn = 1'b1, load = 1'b0, mod_wr = 1'b0;
  logic         one_shot = 1'b0, start = 1'b0;
  logic [N-1:0] load_val = '0, mod_val = '0;
  logic [N-1:0] count, mod_q;
  logic         complete_tick, done;
  state_t       fsm_state;

  int total = 0;
  int bad = 0;

  int m_cnt, m_mod;
  bit m_run, m_fin;
  logic last_tick;

  mod_m_counter_prog #(.N(N), .M_DEFAULT(M_DEF)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .up_dn         (up_dn),
    .load          (load),
    .load_val      (load_val),
    .mod_wr        (mod_wr),
    .mod_val       (mod_val),
    .one_shot      (one_shot),
    .start         (start),
    .count         (count),
    .complete_tick (complete_tick),
    .done          (done),
    .mod_q         (mod_q),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_mod = M_DEF;
    m_run = 1'b0;
    m_fin = 1'b0;
  endtask

  // One clock: check outputs at the negedge, then advance the model across the posedge.
  task automatic step();
    int  top, n_cnt, n_mod;
    bit  term, n_run, n_fin, exp_tick;
    @(negedge clk);
    top  = m_mod - 1;
    term = up_dn ? (m_cnt >= top) : (m_cnt == 0);
    exp_tick = en && m_run && term && !load;
    check("count", 32'(count), 32'(m_cnt));
    check("mod_q", 32'(mod_q), 32'(m_mod));
    check("done", 32'(done), 32'(m_fin));
    check("tick", 32'(complete_tick), 32'(exp_tick));
    last_tick = complete_tick;
    n_cnt = m_cnt; n_mod = m_mod; n_run = m_run; n_fin = m_fin;
    if (load) begin
      n_cnt = (int'(load_val) < top) ? int'(load_val) : top;
    end else if (start && one_shot && !m_run) begin
      n_cnt = up_dn ? 0 : top;
      n_run = 1'b1;
      n_fin = 1'b0;
    end else if (!m_run && !m_fin) begin
      if (!one_shot) n_run = 1'b1;
    end else if (m_run) begin
      if (en) begin
        if (up_dn) n_cnt = term ? 0 : m_cnt + 1;
        else if (term) n_cnt = top;
        else n_cnt = (m_cnt > top) ? top : m_cnt - 1;
        if (one_shot && term) begin
          n_run = 1'b0;
          n_fin = 1'b1;
        end
      end
    end else if (!one_shot) begin
      n_run = 1'b1;
      n_fin = 1'b0;
    end
    if (mod_wr && mod_val != 0) n_mod = int'(mod_val);
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_mod = n_mod; m_run = n_run; m_fin = n_fin;
  endtask

  // Reset is asserted between clock edges; the outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_mod_q", 32'(mod_q), 32'(M_DEF));
    check("rst_done", 32'(done), 32'd0);
    check("rst_tick", 32'(complete_tick), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic write_mod(input int m);
    mod_wr = 1'b1;
    mod_val = N'(m);
    step();
    mod_wr = 1'b0;
  endtask

  initial begin
    model_reset();
    #7;
    check("init_count", 32'(count), 32'd0);
    check("init_mod_q", 32'(mod_q), 32'(M_DEF));
    check("init_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Free-run up, an asynchronous reset in the middle of the count, then down.
    en = 1'b1; up_dn = 1'b1; one_shot = 1'b0;
    repeat (4) step();
    do_reset();
    repeat (8) step();
    up_dn = 1'b0;
    repeat (8) step();

    // Shrink the modulus while count = 7 and mod_q = 10.
    up_dn = 1'b1;
    write_mod(10);
    load = 1'b1; load_val = 8'd7;
    step();
    load = 1'b0; en = 1'b0; mod_wr = 1'b1; mod_val = 8'd4;
    step();
    mod_wr = 1'b0; en = 1'b1;
    step();
    check("shrink_tick", 32'(last_tick), 32'd1);
    repeat (9) step();
    write_mod(0);
    check("mod_zero_ignored", 32'(mod_q), 32'd4);

    // One-shot up with M = 3, started twice.
    write_mod(3);
    one_shot = 1'b1;
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    check("oneshot_done", 32'(done), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    repeat (6) step();

    // Load has priority over a terminal count and over start.
    write_mod(5);
    one_shot = 1'b0;
    step(); step();
    load = 1'b1; load_val = 8'd4;
    step();
    load_val = 8'd9;
    step();
    check("load_clamp", 32'(count), 32'd4);
    load = 1'b0; one_shot = 1'b1;
    repeat (3) step();
    load = 1'b1; start = 1'b1; load_val = 8'd2;
    step();
    load = 1'b0; start = 1'b0;
    repeat (4) step();

    // mod_q = 1 with en toggling.
    one_shot = 1'b0;
    write_mod(1);
    repeat (16) begin
      en = 1'($urandom_range(0, 1));
      step();
    end

    // Random mix.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 30) == 0) one_shot = ~one_shot;
      load     = ($urandom_range(0, 15) == 0);
      load_val = N'($urandom_range(0, 255));
      mod_wr   = ($urandom_range(0, 19) == 0);
      mod_val  = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : N'($urandom_range(0, 20));
      start    = ($urandom_range(0, 7) == 0);
      step();
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
